raw_binning_gray: RTL and testbench
===================================

Name: raw_binning_gray

Overview:
- Consumes the 8-bit RAW/gray stream from the CMOS capture stage: frame vsync, href, clken and data, all in the pixel clock domain.
- Performs 2x2 binning, averaging each non-overlapping 2x2 pixel block into one 8-bit gray pixel.
- Output is half resolution in each axis and feeds the downstream frame buffer write path.
- Uses a single half-line buffer and produces per-frame status (pixel count, line error) for the user interface.

Parameters:
IMG_HDISP, 640, active pixels per input line (even, >=4)
IMG_VDISP, 480, active lines per input frame (even, >=2)

Ports:
clk  input  1  pixel clock (cmos_pclk domain)
rst_n  input  1  asynchronous active-low reset
per_frame_vsync  input  1  input frame valid, high for the whole frame
per_frame_href  input  1  input line valid
per_frame_clken  input  1  input pixel qualifier; data is valid only when href and clken are both high
per_img_raw  input  8  input pixel
post_frame_vsync  output  1  per_frame_vsync delayed 1 clk
post_frame_href  output  1  high while an odd (second-of-pair) input line is active, delayed 1 clk
post_frame_clken  output  1  one-cycle strobe per binned output pixel
post_img_gray  output  8  binned gray pixel, valid when post_frame_clken is high
frame_done  output  1  one-cycle pulse on the falling edge of per_frame_vsync
frame_pix_cnt  output  18  output pixels produced in the last completed frame
line_err  output  1  sticky flag: some line in the current frame had a pixel count different from IMG_HDISP

Behaviour:
- Clock and reset: single clock `clk`; `rst_n` is asynchronous, active-low.
- Reset values: all outputs 0. Internal counters, parity bits, pipeline registers and edge registers are 0. Line buffer contents are don't-care.
- Edge detection: per_frame_vsync and per_frame_href are each registered once.
  - vs_rise = vsync & ~vsync_d; vs_fall = ~vsync & vsync_d.
  - hs_fall = ~href & href_d.
- Pixel accept: accept = per_frame_href & per_frame_clken.
- Column counter x (10 bits min, sized by $clog2):
  - Increments on each accept.
  - Saturates at IMG_HDISP; pixels beyond that are ignored.
  - Cleared on hs_fall.
- Row parity bit row_odd:
  - Cleared on vs_rise.
  - Toggles on hs_fall while vsync is high.
- Pair register: on accept with x even, latch pix_e <= per_img_raw. On accept with x odd, pair_sum = pix_e + per_img_raw (9 bits, no overflow).
- Even row, odd x: write pair_sum into linebuf[x>>1]. Depth is IMG_HDISP/2, width 9, synchronous write.
- Odd row, odd x: read linebuf[x>>1] (combinational read, or read address issued at the even pixel; either way the result is aligned).
  - total = linebuf + pair_sum (10 bits, max 1020).
  - Register post_img_gray <= total[9:2] (truncation, no rounding).
  - Assert post_frame_clken for exactly 1 cycle, so latency is 1 clk from the accepting cycle.
- post_frame_href = href_d & row_odd_d. It is a timing marker only; consumers qualify data with clken.
- Line error check at each hs_fall:
  - If x != IMG_HDISP, set line_err.
  - line_err is cleared only on vs_rise.
  - Extra pixels produce no output. Short lines produce only the pairs that completed.
- Pixel count:
  - Internal counter increments per post_frame_clken and is cleared on vs_rise.
  - On vs_fall: frame_pix_cnt <= counter, and frame_done pulses the next cycle.
  - Nominal value is (IMG_HDISP/2)*(IMG_VDISP/2).
- Odd number of lines in a frame: the trailing even row is stored but never emitted. No error is raised for this.
- Simultaneous events:
  - If vs_rise and accept occur in the same cycle, the pixel belongs to row 0, x=0.
  - If hs_fall and vs_fall occur in the same cycle, the line check applies before frame_pix_cnt is captured.
- Reset mid-frame: all state clears immediately. Output resumes at the next vs_rise. The partial frame produces no frame_done.
- Stalls: clken gaps (clken low with href high) hold all state. Output pixel order is unaffected.

Test Plan:
- IMG_HDISP=4, IMG_VDISP=2, rows {10,20,30,40},{50,60,70,80}, clken continuous -> outputs 35 then 55 on two clken strobes, each 1 clk after the 2nd and 4th pixel of row 1. frame_pix_cnt=2, frame_done pulse, line_err=0.
- All pixels 255 with default params -> every output 255, frame_pix_cnt=76800.
- Rows {1,2,0,0},{0,0,0,0} -> first output (1+2)>>2 = 0 (truncation check); second output 0.
- clken toggling 1/0 every cycle on the first scenario's data -> same outputs 35 and 55, no extra strobes.
- Second line 6 pixels (IMG_HDISP=4) -> line_err=1 after that line and 2 outputs for the line (extras ignored). line_err=0 after the next vs_rise.
- Assert rst_n low mid-row-1 -> all outputs 0 immediately, no frame_done for that frame. The next full frame gives the correct 35/55.

Source files
------------

// File: rtl/raw_binning_gray.sv
// rtl/raw_binning_gray.sv - 2x2 binning of an 8-bit RAW/gray pixel stream with per-frame status
module raw_binning_gray #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic [7:0]  per_img_raw,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic [7:0]  post_img_gray,
    output logic        frame_done,
    output logic [17:0] frame_pix_cnt,
    output logic        line_err
);

    localparam int XB   = $clog2(IMG_HDISP + 1);
    localparam int XW   = (XB > 10) ? XB : 10;
    localparam int HALF = IMG_HDISP / 2;
    localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [XW-1:0] X_END = XW'(IMG_HDISP);

    if ((IMG_HDISP % 2) != 0 || IMG_HDISP < 4 || (IMG_VDISP % 2) != 0 || IMG_VDISP < 2) begin : g_param_check
        $error("raw_binning_gray: image geometry must be even with HDISP >= 4 and VDISP >= 2");
    end

    logic          vsync_d;
    logic          href_d;
    logic          armed;      // a low vsync has been seen since reset, so the next rise is a real frame start
    logic          in_frame;
    logic [XW-1:0] x;
    logic          x_ovf;      // pixels arrived after the line was already full
    logic          row_odd;
    logic [7:0]    pix_e;
    logic [17:0]   pix_cnt;
    logic [8:0]    linebuf [HALF];

    logic          vs_rise;
    logic          vs_fall;
    logic          hs_fall;
    logic          accept;
    logic          take;
    logic          extra;
    logic [XW-1:0] x_cur;
    logic          row_cur;
    logic [8:0]    pair_sum;
    logic [AW-1:0] lb_idx;
    logic [9:0]    total;
    logic          line_bad;
    logic          emit;

    // Edge decode and per-pixel datapath; a vs_rise cycle sees x and row already restarted
    assign vs_rise  = per_frame_vsync & ~vsync_d & armed;
    assign vs_fall  = ~per_frame_vsync & vsync_d & in_frame;
    assign hs_fall  = ~per_frame_href & href_d;
    assign accept   = per_frame_href & per_frame_clken & (in_frame | vs_rise);
    assign x_cur    = vs_rise ? '0 : x;
    assign row_cur  = vs_rise ? 1'b0 : row_odd;
    assign take     = accept & (x_cur != X_END);
    assign extra    = accept & (x_cur == X_END);
    assign pair_sum = {1'b0, pix_e} + {1'b0, per_img_raw};
    assign lb_idx   = AW'(x_cur >> 1);
    assign total    = {1'b0, linebuf[lb_idx]} + {1'b0, pair_sum};
    assign line_bad = (x != X_END) | x_ovf;
    assign emit     = take & x_cur[0] & row_cur;

    // Frame/line tracking: edge registers, column counter, row parity and line error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d  <= 1'b0;
            href_d   <= 1'b0;
            armed    <= 1'b0;
            in_frame <= 1'b0;
            x        <= '0;
            x_ovf    <= 1'b0;
            row_odd  <= 1'b0;
            pix_e    <= '0;
            line_err <= 1'b0;
        end else begin
            vsync_d <= per_frame_vsync;
            href_d  <= per_frame_href;
            armed   <= armed | ~per_frame_vsync;

            if (vs_rise) begin
                in_frame <= 1'b1;
            end else if (vs_fall) begin
                in_frame <= 1'b0;
            end

            if (hs_fall) begin
                x     <= '0;
                x_ovf <= 1'b0;
            end else begin
                if (take) begin
                    x <= x_cur + 1'b1;
                end else if (vs_rise) begin
                    x <= '0;
                end
                if (vs_rise) begin
                    x_ovf <= 1'b0;
                end else if (extra) begin
                    x_ovf <= 1'b1;
                end
            end

            if (vs_rise) begin
                row_odd <= 1'b0;
            end else if (hs_fall && per_frame_vsync && in_frame) begin
                row_odd <= ~row_odd;
            end

            if (take && !x_cur[0]) begin
                pix_e <= per_img_raw;
            end

            if (vs_rise) begin
                line_err <= 1'b0;
            end else if (hs_fall && in_frame && line_bad) begin
                line_err <= 1'b1;
            end
        end
    end

    // Even rows park their horizontal pair sums for the odd row that follows
    always_ff @(posedge clk) begin
        if (take && x_cur[0] && !row_cur) begin
            linebuf[lb_idx] <= pair_sum;
        end
    end

    // Output stage and per-frame pixel accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_gray    <= '0;
            pix_cnt          <= '0;
            frame_pix_cnt    <= '0;
            frame_done       <= 1'b0;
        end else begin
            post_frame_vsync <= per_frame_vsync;
            post_frame_href  <= per_frame_href & row_cur;
            post_frame_clken <= emit;
            if (emit) begin
                post_img_gray <= 8'(total >> 2);
            end

            if (vs_rise) begin
                pix_cnt <= '0;
            end else if (post_frame_clken) begin
                pix_cnt <= pix_cnt + 18'd1;
            end

            // A strobe still in the output register belongs to the frame that is closing
            if (vs_fall) begin
                frame_pix_cnt <= pix_cnt + 18'(post_frame_clken);
            end
            frame_done <= vs_fall;
        end
    end

endmodule

// File: tb/tb_raw_binning_gray.sv
// tb/tb_raw_binning_gray.sv - randomized and directed bench for raw_binning_gray against a block-average model
module tb_raw_binning_gray;

    localparam int H = 4;
    localparam int V = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic        clken = 1'b0;
    logic [7:0]  raw = 8'd0;
    logic        post_frame_vsync;
    logic        post_frame_href;
    logic        post_frame_clken;
    logic [7:0]  post_img_gray;
    logic        frame_done;
    logic [17:0] frame_pix_cnt;
    logic        line_err;

    raw_binning_gray #(.IMG_HDISP(H), .IMG_VDISP(V)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .per_frame_vsync  (vsync),
        .per_frame_href   (href),
        .per_frame_clken  (clken),
        .per_img_raw      (raw),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_gray    (post_img_gray),
        .frame_done       (frame_done),
        .frame_pix_cnt    (frame_pix_cnt),
        .line_err         (line_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        int v;
    } exp_t;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         exp_done = 0;
    bit         live = 1'b0;
    bit         cur_odd = 1'b0;
    bit         rst_pending = 1'b0;
    exp_t       exp_q[$];
    int         got_q[$];
    logic [7:0] img [0:7][0:7];
    int         line_len [0:7];
    logic       s_vs;
    logic       s_vs_prev;
    logic       s_href_exp;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int blk(input int r, input int c);
        return (int'(img[r-1][c-1]) + int'(img[r-1][c]) + int'(img[r][c-1]) + int'(img[r][c])) / 4;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // What the inputs looked like at the last edge the DUT saw
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_vs       <= 1'b0;
            s_vs_prev  <= 1'b0;
            s_href_exp <= 1'b0;
        end else begin
            s_vs       <= vsync;
            s_vs_prev  <= s_vs;
            s_href_exp <= href & cur_odd & live;
        end
    end

    // Per-cycle compare against the model queue and the delayed-input expectations
    always @(negedge clk) begin
        if (rst_n) begin
            check("post_vsync", post_frame_vsync, s_vs);
            check("post_href", post_frame_href, s_href_exp);
            if (post_frame_clken) begin
                got_q.push_back(int'(post_img_gray));
                if (exp_q.size() == 0) begin
                    check("spurious_clken", post_frame_clken, 0);
                end else begin
                    check("clken_cycle", cyc, exp_q[0].c);
                    check("gray", post_img_gray, exp_q[0].v);
                    void'(exp_q.pop_front());
                end
            end else if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
                check("missing_clken", post_frame_clken, 1);
                void'(exp_q.pop_front());
            end
            if (frame_done) done_cnt++;
            if (s_vs && !s_vs_prev && live) check("line_err_cleared_at_vs_rise", line_err, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rst_pending) begin
            rst_n = 1'b1;
            rst_pending = 1'b0;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_vsync"}, post_frame_vsync, 0);
        check({tag, "_href"}, post_frame_href, 0);
        check({tag, "_clken"}, post_frame_clken, 0);
        check({tag, "_gray"}, post_img_gray, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_pixcnt"}, frame_pix_cnt, 0);
        check({tag, "_line_err"}, line_err, 0);
    endtask

    // One frame from img/line_len; cmode 0 continuous clken, 1 toggling, 2 random gaps
    task automatic drive_frame(input int nl, input int cmode, input int rst_line, input int rst_pix,
                               input int start_gap, input bit end_together);
        int exp_cnt;
        int exp_err;
        bit tog;
        bit on;
        exp_cnt = 0;
        exp_err = 0;
        tog = 1'b0;
        repeat (2) begin
            step();
            vsync = 1'b0;
            href  = 1'b0;
            clken = 1'($urandom_range(0, 1));
            raw   = 8'($urandom_range(0, 255));
        end
        live = 1'b1;
        cur_odd = 1'b0;
        if (start_gap > 0) begin
            step();
            vsync = 1'b1;
            href  = 1'b0;
            clken = 1'b0;
            repeat (start_gap - 1) step();
        end
        for (int r = 0; r < nl; r++) begin
            for (int c = 0; c < line_len[r]; ) begin
                step();
                vsync = 1'b1;
                href  = 1'b1;
                cur_odd = 1'(r % 2);
                tog = ~tog;
                on = (cmode == 0) ? 1'b1 : (cmode == 1) ? tog : ($urandom_range(0, 9) < 7);
                if (!on) begin
                    clken = 1'b0;
                    raw   = 8'($urandom_range(0, 255));
                    continue;
                end
                clken = 1'b1;
                raw   = img[r][c];
                if (live && (r % 2) == 1 && (c % 2) == 1 && c < H) begin
                    exp_q.push_back('{c: cyc + 1, v: blk(r, c)});
                    exp_cnt++;
                end
                if (r == rst_line && c == rst_pix) begin
                    rst_n = 1'b0;
                    rst_pending = 1'b1;
                    live = 1'b0;
                    exp_q.delete();
                    #1;
                    check_outputs_zero("mid_frame_reset");
                end
                c++;
            end
            if (line_len[r] != H) exp_err = 1;
            step();
            href  = 1'b0;
            clken = 1'b0;
            if (r == nl - 1 && end_together) begin
                vsync = 1'b0;
            end else begin
                repeat ($urandom_range(0, 2)) step();
            end
        end
        if (!end_together) begin
            step();
            vsync = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        if (live) begin
            exp_done++;
            check("frame_done_pulse", frame_done, 1);
            check("frame_pix_cnt", frame_pix_cnt, exp_cnt);
            check("frame_line_err", line_err, exp_err);
        end else begin
            check("no_frame_done_after_reset", frame_done, 0);
            check("pix_cnt_after_reset", frame_pix_cnt, 0);
        end
        @(negedge clk);
        check("frame_done_width", frame_done, 0);
        check("exp_queue_drained", exp_q.size(), 0);
    endtask

    task automatic load2(input logic [31:0] a, input logic [31:0] b, input int len1);
        for (int c = 0; c < 4; c++) begin
            img[0][c] = a[31 - 8*c -: 8];
            img[1][c] = b[31 - 8*c -: 8];
        end
        line_len[0] = 4;
        line_len[1] = len1;
    endtask

    task automatic expect2(input string name, input int a, input int b);
        check({name, "_count"}, got_q.size(), 2);
        if (got_q.size() == 2) begin
            check({name, "_first"}, got_q[0], a);
            check({name, "_second"}, got_q[1], b);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int nl;
        for (int r = 0; r < 8; r++) begin
            line_len[r] = 0;
            for (int c = 0; c < 8; c++) img[r][c] = 8'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        load2({8'd10, 8'd20, 8'd30, 8'd40}, {8'd50, 8'd60, 8'd70, 8'd80}, 4);
        got_q.delete();
        drive_frame(2, 0, -1, -1, 1, 1'b0);
        expect2("basic", 35, 55);
        check("basic_pix_cnt", frame_pix_cnt, 2);
        check("basic_line_err", line_err, 0);

        load2({8'd1, 8'd2, 8'd0, 8'd0}, 32'd0, 4);
        got_q.delete();
        drive_frame(2, 0, -1, -1, 0, 1'b0);
        expect2("truncation", 0, 0);

        load2({8'd10, 8'd20, 8'd30, 8'd40}, {8'd50, 8'd60, 8'd70, 8'd80}, 4);
        got_q.delete();
        drive_frame(2, 1, -1, -1, 1, 1'b0);
        expect2("clken_toggle", 35, 55);

        load2({8'd10, 8'd20, 8'd30, 8'd40}, {8'd50, 8'd60, 8'd70, 8'd80}, 6);
        img[1][4] = 8'd90;
        img[1][5] = 8'd100;
        got_q.delete();
        drive_frame(2, 0, -1, -1, 1, 1'b1);
        expect2("long_line", 35, 55);
        check("long_line_err", line_err, 1);
        check("long_line_pix_cnt", frame_pix_cnt, 2);

        load2({8'd10, 8'd20, 8'd30, 8'd40}, {8'd50, 8'd60, 8'd70, 8'd80}, 4);
        got_q.delete();
        drive_frame(2, 0, -1, -1, 1, 1'b0);
        check("line_err_next_frame", line_err, 0);

        drive_frame(2, 0, 1, 1, 1, 1'b0);
        got_q.delete();
        drive_frame(2, 0, -1, -1, 1, 1'b0);
        expect2("after_reset", 35, 55);

        load2({4{8'd255}}, {4{8'd255}}, 4);
        got_q.delete();
        drive_frame(2, 2, -1, -1, 2, 1'b0);
        expect2("all_255", 255, 255);

        for (int f = 0; f < 40; f++) begin
            bit sat;
            nl = $urandom_range(1, 6);
            sat = ($urandom_range(0, 9) == 0);
            for (int r = 0; r < nl; r++) begin
                if ((r % 2) == 1)
                    line_len[r] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, H + 2) : H;
                else
                    line_len[r] = ($urandom_range(0, 5) == 0) ? H + $urandom_range(1, 2) : H;
                for (int c = 0; c < 8; c++) img[r][c] = sat ? 8'd255 : 8'($urandom_range(0, 255));
            end
            drive_frame(nl, 2, -1, -1, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("frame_done_count", done_cnt, exp_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
